// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures an asynchronous divided clock/strobe in clock_in cycles and
//   reports the period (rising edge to rising edge) and the high time within
//   that period. Used to check divider outputs against the programmed divisor.
//
// Ports
//   clock_in    in   1      system clock, all logic on posedge
//   rst_n       in   1      synchronous active-low reset
//   sig_in      in   1      asynchronous signal under measurement
//   period_out  out  CNT_W  last measured period in cycles
//   high_out    out  CNT_W  high cycles within that period
//   meas_valid  out  1      one-cycle pulse when period_out/high_out update
//   locked      out  1      two consecutive equal raw periods seen
//   timeout     out  1      sticky; set after TIMEOUT cycles without a rise,
//                           cleared by the next valid measurement
//
// Optional feature
//   CLK_PERIOD_METER_AVG_EN : period_out reports the mean of the last four
//   measured periods; meas_valid is held off until four measurements exist.

module clk_period_meter #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 100_000_000
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [0:0] S_WAIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [0:0]             state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sig_s;
    logic                   sig_d;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       hcnt_inc;
    logic [CNT_W-1:0]       prev;

`ifdef CLK_PERIOD_METER_AVG_EN
    logic [CNT_W-1:0] hist [4];
    logic [1:0]       n_meas;   // measurements since S_WAIT, saturating at 3
    logic [CNT_W+1:0] sum;

    // Sum of the period being completed now plus the three most recent ones.
    always_comb begin
        sum = {2'b00, cnt} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    end
`endif

    assign sig_s = sync[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;

    // Saturating increments; hcnt only advances while the synced input is high.
    always_comb begin
        cnt_inc  = (cnt == '1) ? cnt : cnt + ONE;
        hcnt_inc = (sig_s && (hcnt != '1)) ? hcnt + ONE : hcnt;
    end

    always_ff @(posedge clock_in) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            sync       <= '0;
            sig_d      <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            prev       <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
            for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
            n_meas <= '0;
`endif
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], sig_in};
            sig_d      <= sig_s;
            meas_valid <= 1'b0;

            case (state)
                S_WAIT: begin
                    cnt  <= '0;
                    hcnt <= '0;
                    if (rise) begin
                        cnt   <= ONE;
                        hcnt  <= ONE;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (rise) begin
                        // cnt/hcnt hold the completed period here; the rise
                        // cycle itself opens the next period.
                        cnt      <= ONE;
                        hcnt     <= ONE;
                        high_out <= hcnt;
                        locked   <= (cnt == prev);
                        prev     <= cnt;
`ifdef CLK_PERIOD_METER_AVG_EN
                        hist[0] <= cnt;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        hist[3] <= hist[2];
                        if (n_meas != 2'd3) begin
                            n_meas <= n_meas + 2'd1;
                        end else begin
                            period_out <= sum[CNT_W+1:2];
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                        end
`else
                        period_out <= cnt;
                        meas_valid <= 1'b1;
                        timeout    <= 1'b0;
`endif
                    end else if (cnt == TO_CNT) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        prev    <= '0;
                        cnt     <= '0;
                        hcnt    <= '0;
                        state   <= S_WAIT;
`ifdef CLK_PERIOD_METER_AVG_EN
                        for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
                        n_meas <= '0;
`endif
                    end else begin
                        cnt  <= cnt_inc;
                        hcnt <= hcnt_inc;
                    end
                end

                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//   Directed bench for clk_period_meter (TIMEOUT overridden to 50). A
//   background generator emulates a clock divider on sig_in with
//   programmable high/low lengths, changing on the falling clock edge.

module tb_clk_period_meter;

    localparam int unsigned CNT_W = 28;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned hi_len = 5;
    int unsigned lo_len = 5;
    int unsigned ph     = 0;
    bit          gen_en = 1'b0;
    int          rises_gen = 0;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT    (50)
    ) dut (
        .clock_in  (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Divider emulation: high for hi_len cycles, then low for lo_len cycles.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!gen_en) begin
                sig_in = 1'b0;
                ph     = 0;
            end else begin
                if (ph == 0) begin
                    sig_in = 1'b1;
                    rises_gen++;
                end else if (ph == hi_len) begin
                    sig_in = 1'b0;
                end
                ph = ph + 1;
                if (ph >= hi_len + lo_len) ph = 0;
            end
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic restart(input int unsigned h, input int unsigned l);
        gen_en = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rises_gen = 0;
        hi_len    = h;
        lo_len    = l;
        gen_en    = 1'b1;
    endtask

    task automatic test_reset;
        bit bad;
        rst_n  = 1'b0;
        hi_len = 5;
        lo_len = 5;
        gen_en = 1'b1;
        bad    = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (period_out != 0 || high_out != 0 || meas_valid || locked || timeout) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: outputs nonzero during reset, got %b expected 0", bad);
        end
        n_cmp++;
        if (period_out !== '0) begin
            n_err++;
            $display("FAIL reset_period: got %0d expected 0", period_out);
        end
        gen_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({meas_valid, locked, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: valid/locked/timeout got %b expected 000",
                     {meas_valid, locked, timeout});
        end
    endtask

    task automatic test_div10;
        bit ok;
        restart(5, 5);
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || rises_gen !== 2) begin
            n_err++;
            $display("FAIL div10_first: valid %b at rise %0d expected valid at rise 2", ok, rises_gen);
        end
        n_cmp++;
        if (period_out !== 10 || high_out !== 5) begin
            n_err++;
            $display("FAIL div10_meas: period %0d high %0d expected 10 5", period_out, high_out);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL div10_unlocked: locked %b expected 0", locked);
        end
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || locked !== 1'b1 || period_out !== 10) begin
            n_err++;
            $display("FAIL div10_lock: valid %b locked %b period %0d expected 1 1 10", ok, locked, period_out);
        end
    endtask

    task automatic test_div7;
        bit ok;
        restart(3, 4);
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || period_out !== 7 || high_out !== 3 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL div7_meas: valid %b period %0d high %0d locked %b expected 1 7 3 0",
                     ok, period_out, high_out, locked);
        end
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || period_out !== 7 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL div7_lock: valid %b period %0d locked %b expected 1 7 1", ok, period_out, locked);
        end
    endtask

    task automatic test_div_change;
        bit ok;
        restart(5, 5);
        wait_valid(ok);
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL chg_prelock: valid %b locked %b expected 1 1", ok, locked);
        end
        hi_len = 6;
        lo_len = 6;
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || period_out !== 12 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL chg_first12: valid %b period %0d locked %b expected 1 12 0", ok, period_out, locked);
        end
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || period_out !== 12 || high_out !== 6 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL chg_relock: valid %b period %0d high %0d locked %b expected 1 12 6 1",
                     ok, period_out, high_out, locked);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int k;
        restart(5, 5);
        wait_valid(ok);
        wait_valid(ok);
        gen_en = 1'b0;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (timeout) begin
                k = i;
                break;
            end
        end
        n_cmp++;
        if (k !== 50) begin
            n_err++;
            $display("FAIL to_latency: timeout after %0d cycles expected 50", k);
        end
        n_cmp++;
        if (locked !== 1'b0 || period_out !== 10 || meas_valid !== 1'b0) begin
            n_err++;
            $display("FAIL to_state: locked %b period %0d valid %b expected 0 10 0", locked, period_out, meas_valid);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_err++;
            $display("FAIL to_sticky: timeout %b expected 1", timeout);
        end
        rises_gen = 0;
        gen_en    = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || rises_gen !== 2 || timeout !== 1'b0 || period_out !== 10) begin
            n_err++;
            $display("FAIL to_recover: valid %b rise %0d timeout %b period %0d expected 1 2 0 10",
                     ok, rises_gen, timeout, period_out);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        restart(5, 5);
        wait_valid(ok);
        wait_valid(ok);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (period_out !== '0 || high_out !== '0 || {meas_valid, locked, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_zero: period %0d high %0d v/l/t %b expected 0 0 000",
                     period_out, high_out, {meas_valid, locked, timeout});
        end
        rises_gen = 0;
        rst_n     = 1'b1;
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || rises_gen !== 2 || period_out !== 10) begin
            n_err++;
            $display("FAIL midrst_wait: valid %b rise %0d period %0d expected 1 2 10", ok, rises_gen, period_out);
        end
    endtask

`ifdef CLK_PERIOD_METER_AVG_EN
    task automatic test_avg;
        bit ok;
        restart(5, 5);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rises_gen >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        hi_len = 6;
        lo_len = 6;
        n_cmp++;
        if (ok !== 1'b1 || meas_valid !== 1'b0) begin
            n_err++;
            $display("FAIL avg_hold: reached rise3 %b valid %b expected 1 0", ok, meas_valid);
        end
        wait_valid(ok);
        n_cmp++;
        if (ok !== 1'b1 || rises_gen !== 5) begin
            n_err++;
            $display("FAIL avg_first: valid %b at rise %0d expected valid at rise 5", ok, rises_gen);
        end
        n_cmp++;
        if (period_out !== 11 || high_out !== 6 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL avg_value: period %0d high %0d locked %b expected 11 6 1", period_out, high_out, locked);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        test_reset();
`ifdef CLK_PERIOD_METER_AVG_EN
        test_avg();
`else
        test_div10();
        test_div7();
        test_div_change();
        test_timeout();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
